regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the RISC datapath. It provides a configurable width, depth and number of read ports, with registered reads and write-to-read bypass. After reset, a sequencer walks the array and loads entry k with value k, one entry per clock, and asserts `ready` when the walk completes. It replaces the fixed 32×32 two-port file and serves the decode stage, with a combinational probe port for debug.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_init_seq.sv | 49 ++++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the multi-port register file
package regfile_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NR    = 2;

endpackage

// File: rtl/regfile_init_seq.sv
// rtl/regfile_init_seq.sv - post-reset walk loading entry k with k; drives ready and wr_drop
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter  int WIDTH = RF_WIDTH,
  parameter  int DEPTH = RF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  output logic             ready,
  output logic             wr_drop,
  output logic             init_we,
  output logic [AW-1:0]    init_addr,
  output logic [WIDTH-1:0] init_data
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_t     state;
  logic [AW-1:0] cnt;

  // cnt parks on LAST once the walk is done so it never wraps back to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_INIT;
      cnt     <= '0;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= 1'b0;
      if (state == RF_INIT) begin
        wr_drop <= we;
        if (cnt == LAST) begin
          state <= RF_RUN;
          ready <= 1'b1;
        end else begin
          cnt <= cnt + AW'(1);
        end
      end
    end
  end

  assign init_we   = (state == RF_INIT) && !rst;
  assign init_addr = cnt;
  assign init_data = WIDTH'(cnt);

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NR-read-port register file with registered reads, write bypass and debug probe
// REGFILE_ZERO_REG_EN: hardwires entry 0 to zero (reads, probe, bypass and writes to address 0)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH = RF_WIDTH,
  parameter  int DEPTH = RF_DEPTH,
  parameter  int NR    = RF_NR,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [NR*AW-1:0]    raddr,
  output logic [NR*WIDTH-1:0] rdata,
  output logic                ready,
  output logic                wr_drop,
  input  logic [AW-1:0]       probe_addr,
  output logic [WIDTH-1:0]    probe_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             init_we;
  logic [AW-1:0]    init_addr;
  logic [WIDTH-1:0] init_data;
  logic             zero_hit;
  logic             user_we;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  regfile_init_seq #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .ready     (ready),
    .wr_drop   (wr_drop),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

`ifdef REGFILE_ZERO_REG_EN
  assign zero_hit = (waddr == '0);
`else
  assign zero_hit = 1'b0;
`endif

  // user writes only land in RUN; reset on the same edge discards them
  assign user_we   = we && ready && !rst && !zero_hit;
  assign mem_we    = init_we || user_we;
  assign mem_addr  = init_we ? init_addr : waddr;
  assign mem_wdata = init_we ? init_data : wdata;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  function automatic logic [WIDTH-1:0] entry(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    if (a == '0) return '0;
`endif
    return mem[a];
  endfunction

  always_ff @(posedge clk) begin
    for (int p = 0; p < NR; p++) begin
      if (rst || !ready) begin
        rdata[p*WIDTH +: WIDTH] <= '0;
      end else if (user_we && (waddr == raddr[p*AW +: AW])) begin
        rdata[p*WIDTH +: WIDTH] <= wdata;
      end else begin
        rdata[p*WIDTH +: WIDTH] <= entry(raddr[p*AW +: AW]);
      end
    end
  end

  assign probe_data = entry(probe_addr);

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp at default sizes
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int NR = 2;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [W-1:0]     wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*W-1:0]  rdata;
  logic             ready;
  logic             wr_drop;
  logic [AW-1:0]    probe_addr;
  logic [W-1:0]     probe_data;

  typedef struct {
    string      tag;
    int         port;
    logic [W-1:0] val;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model [D];
  int           n_tests;
  int           n_fail;

  regfile_mp dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .ready      (ready),
    .wr_drop    (wr_drop),
    .probe_addr (probe_addr),
    .probe_data (probe_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic zero_addr(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return a == '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] model_rd(input logic [AW-1:0] a);
    return zero_addr(a) ? '0 : model[a];
  endfunction

  task automatic expect_rd(input string tag, input logic [W-1:0] v0, input logic [W-1:0] v1);
    exp_t e;
    e.tag = {tag, "_p0"}; e.port = 0; e.val = v0; sb.push_back(e);
    e.tag = {tag, "_p1"}; e.port = 1; e.val = v1; sb.push_back(e);
  endtask

  // one clock edge, then score every read expected for that edge
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, rdata[e.port*W +: W], e.val);
    end
  endtask

  task automatic probe(input logic [AW-1:0] a, input string tag);
    probe_addr = a;
    #1;
    check(tag, probe_data, model_rd(a));
  endtask

  task automatic walk(input int n, input int drop_edge);
    for (int e = 1; e <= n; e++) begin
      we    = (e == drop_edge);
      waddr = 5'd3;
      wdata = 32'h0000_DEAD;
      raddr = {5'd7, 5'd5};
      expect_rd("init_rd", '0, '0);
      step();
      we = 1'b0;
      check("init_ready", W'(ready), W'(e == D));
      check("init_drop", W'(wr_drop), W'(e == drop_edge));
      probe_addr = AW'(e - 1);
      #1;
      check("init_probe", probe_data, W'(e - 1));
    end
    if (n == D) for (int k = 0; k < D; k++) model[k] = W'(k);
  endtask

  task automatic cyc(input logic w, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                     input logic [AW-1:0] r0, input logic [AW-1:0] r1, input string tag);
    logic         byp;
    logic [W-1:0] e0, e1;
    byp = w && !zero_addr(wa);
    e0  = (byp && wa == r0) ? wd : model_rd(r0);
    e1  = (byp && wa == r1) ? wd : model_rd(r1);
    we = w; waddr = wa; wdata = wd; raddr = {r1, r0};
    expect_rd(tag, e0, e1);
    step();
    we = 1'b0;
    if (byp) model[wa] = wd;
    check({tag, "_drop"}, W'(wr_drop), '0);
  endtask

  task automatic reset_cycle(input string tag);
    rst = 1'b1;
    expect_rd(tag, '0, '0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; probe_addr = '0;
    for (int i = 0; i < 3; i++) begin
      expect_rd("rst_rd", '0, '0);
      step();
    end
    check("rst_ready", W'(ready), '0);
    check("rst_drop", W'(wr_drop), '0);
    rst = 1'b0;

    walk(D, 2);
    probe(5'd5, "probe5");
    probe(5'd31, "probe31");
    cyc(1'b0, 5'd0, '0, 5'd3, 5'd31, "rd_after_drop");

    cyc(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd1, 5'd2, "wr7");
    cyc(1'b0, 5'd0, '0, 5'd7, 5'd6, "rd76");

    probe(5'd9, "probe9_old");
    cyc(1'b1, 5'd9, 32'h0000_1234, 5'd9, 5'd9, "bypass9");
    probe(5'd9, "probe9_new");

    for (int i = 0; i < 24; i++) begin
      logic [AW-1:0] wa, r0, r1;
      wa = AW'($urandom_range(0, D - 1));
      r0 = AW'($urandom_range(0, D - 1));
      r1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, D - 1));
      cyc(1'($urandom_range(0, 1)), wa, $urandom, r0, r1, "rand");
    end

    cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "zero_wr");
    cyc(1'b0, 5'd0, '0, 5'd0, 5'd0, "zero_rd");
    probe(5'd0, "zero_probe");

    reset_cycle("rst_a");
    walk(10, 0);
    reset_cycle("rst_mid_init");
    walk(D, 0);
    cyc(1'b0, 5'd0, '0, 5'd9, 5'd7, "post_mid_init");

    cyc(1'b1, 5'd4, 32'h0000_00FF, 5'd3, 5'd2, "w4");
    cyc(1'b0, 5'd0, '0, 5'd4, 5'd4, "rd4_ff");
    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h0000_BEEF;
    expect_rd("rst_we", '0, '0);
    step();
    rst = 1'b0; we = 1'b0;
    check("rst_we_drop", W'(wr_drop), '0);
    check("rst_we_ready", W'(ready), '0);
    walk(D, 0);
    cyc(1'b0, 5'd0, '0, 5'd4, 5'd5, "post_run_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
